osc_edge_counter: RTL and testbench

Measurement stage downstream of the gf180 OSU 9T AND2 oscillator gate.
- EN_OUT drives the gate's enable input (B); the gate's output (Y) returns as GATED_IN.
- The block opens a gating window of programmable length in CLK cycles and counts rising edges of the gated oscillator during it.
- It then holds the result under a VALID/ACK handshake for the tempsense/readout logic.

---
 rtl/osc_cnt_pkg.sv | 21 ++
 rtl/osc_cnt_sync.sv | 35 +++
 rtl/osc_edge_counter.sv | 100 ++++++++++
 tb/tb_osc_edge_counter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_cnt_pkg.sv
// Shared types and constants for the gated-oscillator edge counter.
// The FSM state names double as the top-level WINDOW port name, so importers pick items explicitly.
package osc_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WINDOW,
        SETTLE,
        DONE
    } state_t;

    localparam int CNT_W_DEF       = 16;
    localparam int WIN_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

    // Largest value COUNT can hold before it saturates.
    function automatic logic [63:0] cnt_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/osc_cnt_sync.sv
// Synchronizer chain plus edge-detect flop for the asynchronous gated oscillator.
// Build option OSC_CNT_BOTH_EDGES_EN: pulse on rising and falling edges instead of rising only.
module osc_cnt_sync
    import osc_cnt_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic osc,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    // NOTE: the chain is a handful of flops, not a memory, so it is cleared
    // on reset; a stale 1 here would otherwise fake an edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], osc};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

`ifdef OSC_CNT_BOTH_EDGES_EN
    assign pulse = chain[SYNC_STAGES-1] ^ prev;
`else
    assign pulse = chain[SYNC_STAGES-1] & ~prev;
`endif

endmodule

// File: rtl/osc_edge_counter.sv
// Gates the oscillator for a programmable window, counts its synchronized edges, then holds the result under VALID/ACK.
// Build option OSC_CNT_BOTH_EDGES_EN (handled in osc_cnt_sync) counts falling edges as well.
module osc_edge_counter
    import osc_cnt_pkg::state_t, osc_cnt_pkg::IDLE, osc_cnt_pkg::SETTLE, osc_cnt_pkg::DONE,
           osc_cnt_pkg::cnt_max, osc_cnt_pkg::CNT_W_DEF, osc_cnt_pkg::WIN_W_DEF,
           osc_cnt_pkg::SYNC_STAGES_DEF;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF   // legal range 2..4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic             GATED_IN,
    output logic             EN_OUT,
    output logic             BUSY,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF,
    output logic             VALID,
    input  logic             ACK
);

    localparam logic [CNT_W-1:0] COUNT_MAX   = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] COUNT_ONE   = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE     = WIN_W'(1);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SYNC_STAGES);

    state_t           state;
    state_t           state_next;
    logic [WIN_W-1:0] win_cnt;
    logic             pulse;
    logic             accept;
    logic             counting;

    osc_cnt_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (CLK),
        .rst  (RST),
        .osc  (GATED_IN),
        .pulse(pulse)
    );

    assign accept   = (state == IDLE) && START;
    assign counting = (state == osc_cnt_pkg::WINDOW) || (state == SETTLE);

    // NOTE: state_next gets its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:                if (START) state_next = (WINDOW != '0) ? osc_cnt_pkg::WINDOW : DONE;
            osc_cnt_pkg::WINDOW: if (win_cnt == WIN_ONE) state_next = SETTLE;
            SETTLE:              if (win_cnt == '0) state_next = DONE;
            DONE:                if (ACK) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Outputs are registered from state_next: same timing as a state decode,
    // but EN_OUT cannot glitch into the oscillator gate.
    // NOTE: every assignment here is non-blocking, so all flops sample
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            win_cnt <= '0;
            COUNT   <= '0;
            OVF     <= 1'b0;
            EN_OUT  <= 1'b0;
            BUSY    <= 1'b0;
            VALID   <= 1'b0;
        end else begin
            state  <= state_next;
            EN_OUT <= (state_next == osc_cnt_pkg::WINDOW);
            BUSY   <= (state_next != IDLE);
            VALID  <= (state_next == DONE);
            if (accept) begin
                win_cnt <= WINDOW;
                COUNT   <= '0;
                OVF     <= 1'b0;
            end else begin
                // win_cnt is reused as the settle counter once the window closes.
                if (state == osc_cnt_pkg::WINDOW)
                    win_cnt <= (win_cnt == WIN_ONE) ? SETTLE_LAST : win_cnt - WIN_ONE;
                else if (state == SETTLE && win_cnt != '0)
                    win_cnt <= win_cnt - WIN_ONE;
                if (counting && pulse) begin
                    if (COUNT == COUNT_MAX)
                        OVF <= 1'b1;
                    else
                        COUNT <= COUNT + COUNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_osc_edge_counter.sv
// Self-checking bench for osc_edge_counter: default instance plus a 4-bit-count instance for saturation.
// Expected counts follow the OSC_CNT_BOTH_EDGES_EN build option.
`timescale 1ns/1ps
module tb_osc_edge_counter;

    localparam int WIN_W = 16;
    localparam int CNT_W = 16;
    localparam int SAT_W = 4;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             start, ack, en_out, busy, ovf, valid, gated;
    logic [WIN_W-1:0] window;
    logic [CNT_W-1:0] count;
    logic             s_start, s_ack, s_en_out, s_busy, s_ovf, s_valid, s_gated;
    logic [WIN_W-1:0] s_window;
    logic [SAT_W-1:0] s_count;

    // Oscillator model: square wave of period 2^(osc_bit+1) cycles, phase set by osc_base.
    int unsigned cyc = 0;
    int unsigned osc_base = 0;
    int          osc_bit = 2;
    logic [31:0] rel;
    logic        osc = 1'b0;
    assign rel = cyc - osc_base;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) osc <= rel[osc_bit];

    assign gated   = en_out & osc;
    assign s_gated = s_en_out & osc;

    osc_edge_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SYNC_STAGES(SYNC)) dut (
        .CLK(clk), .RST(rst), .START(start), .WINDOW(window), .GATED_IN(gated),
        .EN_OUT(en_out), .BUSY(busy), .COUNT(count), .OVF(ovf), .VALID(valid), .ACK(ack)
    );

    osc_edge_counter #(.CNT_W(SAT_W), .WIN_W(WIN_W), .SYNC_STAGES(SYNC)) dut_sat (
        .CLK(clk), .RST(rst), .START(s_start), .WINDOW(s_window), .GATED_IN(s_gated),
        .EN_OUT(s_en_out), .BUSY(s_busy), .COUNT(s_count), .OVF(s_ovf), .VALID(s_valid), .ACK(s_ack)
    );

    typedef struct {
        int   lo;
        int   hi;
        logic ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef OSC_CNT_BOTH_EDGES_EN
    localparam int EDGE_MULT = 2;
`else
    localparam int EDGE_MULT = 1;
`endif

    task automatic issue_start(input bit sat, input int w);
        @(posedge clk); #1;
        if (sat) begin s_start = 1'b1; s_window = WIN_W'(w); end
        else     begin start   = 1'b1; window   = WIN_W'(w); end
        @(posedge clk); #1;
        s_start = 1'b0;
        start   = 1'b0;
    endtask

    task automatic issue_ack(input bit sat);
        @(posedge clk); #1;
        if (sat) s_ack = 1'b1; else ack = 1'b1;
        @(posedge clk); #1;
        s_ack = 1'b0;
        ack   = 1'b0;
    endtask

    // Waits (bounded) for VALID; reports cycles after acceptance and EN_OUT-high cycles.
    task automatic wait_valid(input bit sat, input int budget,
                              output int lat, output int en_cyc, output bit got);
        lat = 0; en_cyc = 0; got = 1'b0;
        while (!got && lat < budget) begin
            @(negedge clk);
            lat++;
            if (sat ? s_en_out : en_out) en_cyc++;
            got = sat ? s_valid : valid;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; ack = 1'b0; window = '0;
        s_start = 1'b0; s_ack = 1'b0; s_window = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (en_out !== 1'b0) begin n_bad++; $display("FAIL reset_en_out: got %b want 0", en_out); end
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (valid !== 1'b0)  begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (ovf !== 1'b0)    begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_cmp++; if (count !== '0)    begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (s_busy !== 1'b0 || s_count !== '0) begin
            n_bad++; $display("FAIL reset_sat: busy %b count %0d want 0/0", s_busy, s_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Full 64-cycle window with an 8-cycle oscillator; reused after the mid-window reset.
    task automatic test_basic_count;
        int lat, en_cyc; bit got; exp_t e;
        exp_q.push_back('{lo: 8 * EDGE_MULT - 1, hi: 8 * EDGE_MULT + 1, ovf: 1'b0});
        osc_bit = 2; osc_base = cyc;
        issue_start(1'b0, 64);
        wait_valid(1'b0, 200, lat, en_cyc, got);
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL basic_timeout: VALID absent after %0d cycles", lat);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (en_cyc !== 64) begin n_bad++; $display("FAIL basic_en_cycles: got %0d want 64", en_cyc); end
            n_cmp++; if (lat !== 64 + SYNC + 2) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", lat, 64 + SYNC + 2); end
            n_cmp++;
            if ($isunknown(count) || count < e.lo || count > e.hi) begin
                n_bad++; $display("FAIL basic_count: got %0d want %0d..%0d", count, e.lo, e.hi);
            end
            n_cmp++; if (ovf !== e.ovf) begin n_bad++; $display("FAIL basic_ovf: got %b want %b", ovf, e.ovf); end
        end
        issue_ack(1'b0);
    endtask

    task automatic test_zero_window;
        int lat, en_cyc; bit got; exp_t e;
        exp_q.push_back('{lo: 0, hi: 0, ovf: 1'b0});
        issue_start(1'b0, 0);
        wait_valid(1'b0, 20, lat, en_cyc, got);
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL zero_timeout: VALID absent after %0d cycles", lat);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (lat !== 1)    begin n_bad++; $display("FAIL zero_latency: got %0d want 1", lat); end
            n_cmp++; if (en_cyc !== 0) begin n_bad++; $display("FAIL zero_en_out: got %0d cycles want 0", en_cyc); end
            n_cmp++; if (count !== CNT_W'(e.lo)) begin n_bad++; $display("FAIL zero_count: got %0d want %0d", count, e.lo); end
            n_cmp++; if (ovf !== e.ovf) begin n_bad++; $display("FAIL zero_ovf: got %b want %b", ovf, e.ovf); end
        end
        issue_ack(1'b0);
    endtask

    task automatic test_saturation;
        int lat, en_cyc; bit got; exp_t e;
        exp_q.push_back('{lo: 15, hi: 15, ovf: 1'b1});
        osc_bit = 1; osc_base = cyc;
        issue_start(1'b1, 200);
        wait_valid(1'b1, 400, lat, en_cyc, got);
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL sat_timeout: VALID absent after %0d cycles", lat);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (s_count !== SAT_W'(e.lo)) begin n_bad++; $display("FAIL sat_count: got %0d want %0d", s_count, e.lo); end
            n_cmp++; if (s_ovf !== e.ovf) begin n_bad++; $display("FAIL sat_ovf: got %b want %b", s_ovf, e.ovf); end
        end
        issue_ack(1'b1);
        // A fresh START must clear both the saturated count and OVF.
        exp_q.push_back('{lo: 0, hi: 0, ovf: 1'b0});
        issue_start(1'b1, 0);
        wait_valid(1'b1, 20, lat, en_cyc, got);
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL sat_restart_timeout: VALID absent after %0d cycles", lat);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            n_cmp++; if (s_count !== SAT_W'(e.lo)) begin n_bad++; $display("FAIL sat_restart_count: got %0d want %0d", s_count, e.lo); end
            n_cmp++; if (s_ovf !== e.ovf) begin n_bad++; $display("FAIL sat_restart_ovf: got %b want %b", s_ovf, e.ovf); end
        end
        issue_ack(1'b1);
        osc_bit = 2;
    endtask

    task automatic test_handshake;
        int lat, en_cyc; bit got; exp_t e;
        logic [CNT_W-1:0] held;
        exp_q.push_back('{lo: 2 * EDGE_MULT - 1, hi: 2 * EDGE_MULT + 1, ovf: 1'b0});
        osc_bit = 2; osc_base = cyc;
        issue_start(1'b0, 16);
        wait_valid(1'b0, 100, lat, en_cyc, got);
        n_cmp++;
        if (!got) begin
            n_bad++; $display("FAIL hs_timeout: VALID absent after %0d cycles", lat);
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            n_cmp++;
            if ($isunknown(count) || count < e.lo || count > e.hi) begin
                n_bad++; $display("FAIL hs_count: got %0d want %0d..%0d", count, e.lo, e.hi);
            end
            held = count;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                start = i[0];
                @(negedge clk);
                n_cmp++;
                if (valid !== 1'b1 || busy !== 1'b1 || count !== held) begin
                    n_bad++;
                    $display("FAIL hs_hold_%0d: valid %b busy %b count %0d want 1/1/%0d", i, valid, busy, count, held);
                end
            end
        end
        // ACK and START together: ACK wins, START is dropped.
        @(posedge clk); #1;
        ack = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++; if (valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL hs_ack: valid %b busy %b want 0/0", valid, busy);
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || en_out !== 1'b0) begin
            n_bad++; $display("FAIL hs_start_dropped: busy %b en_out %b want 0/0", busy, en_out);
        end
    endtask

    task automatic test_reset_mid_window;
        int seen, waited;
        exp_q.push_back('{lo: 0, hi: 0, ovf: 1'b0});
        osc_bit = 2; osc_base = cyc;
        issue_start(1'b0, 64);
        seen = 0; waited = 0;
        while (seen < 10 && waited < 40) begin
            @(negedge clk);
            waited++;
            if (en_out) seen++;
        end
        n_cmp++; if (seen !== 10) begin n_bad++; $display("FAIL rst_mid_window_entry: got %0d EN cycles want 10", seen); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_cmp++; if (en_out !== 1'b0) begin n_bad++; $display("FAIL rst_mid_en_out: got %b want 0", en_out); end
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_cmp++; if (count !== '0)    begin n_bad++; $display("FAIL rst_mid_count: got %0d want 0", count); end
        n_cmp++; if (valid !== 1'b0)  begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", valid); end
        test_basic_count();
    endtask

    initial begin
        test_reset();
        test_basic_count();
        test_zero_window();
        test_saturation();
        test_handshake();
        test_reset_mid_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
